decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV64I decode stage. Holds the IF/ID and ID/EX pipeline registers and sits between fetch and execute.
//  Drives rs1/rs2 to the registerFile read ports and captures Read_Data1/2 into ID/EX.
//  Passes rd/Reg_Write down the pipe; the registerFile write port is driven from writeback.
//  Decodes fields and immediates, flags illegal opcodes and inserts load-use bubbles.
// PARAMETERS
//  XLEN        64  datapath / register width
//  INSTR_W     32  instruction width
//  REG_ADDR_W  5   register index width
// PORTS
//  clk          in   1        pipeline clock, posedge
//  reset        in   1        asynchronous, active-low; clears all state
//  if_valid     in   1        fetch offers if_instr/if_pc
//  if_ready     out  1        IF/ID accepts this cycle
//  if_instr     in   INSTR_W  instruction word
//  if_pc        in   XLEN     instruction address
//  flush        in   1        squash both stage registers (branch redirect)
//  rs1,rs2      out  5        registerFile read addresses, from IF/ID
//  rf_rdata1/2  in   XLEN     registerFile Read_Data1/2, combinational
//  ex_valid     out  1        ID/EX holds a valid op
//  ex_ready     in   1        execute consumes ID/EX
//  ex_pc        out  XLEN     PC of the op
//  ex_op1,ex_op2 out XLEN     captured read data
//  ex_imm       out  XLEN     sign-extended immediate
//  ex_rd        out  5        destination register
//  ex_reg_write out  1        destination written at writeback
//  ex_opcode    out  7        opcode
//  ex_funct3    out  3        funct3
//  ex_funct7    out  7        funct7
//  ex_illegal   out  1        unrecognised opcode
//  stall        out  1        load-use bubble being inserted
// BEHAVIOUR
//  - Reset (async, reset=0): id_valid=0, ex_valid=0, stall=0; every registered ex_* field = 0.
//    if_ready=0 while in reset; rs1/rs2 = 0.
//  - Advance: ex_adv = !ex_valid | ex_ready. id_adv = ex_adv & !stall.
//    if_ready = id_adv & !flush.
//  - Latency: accepted instr appears in ID/EX after 2 clk, given no stall or backpressure.
//  - IF/ID loads if_instr/if_pc/if_valid on id_adv. The instr is held otherwise.
//  - ID/EX on ex_adv: loads the decoded IF/ID contents, with ex_valid=id_valid&!stall.
//    A stall cycle therefore loads a bubble (ex_valid=0).
//  - rs1/rs2 come from IF/ID. They are forced 0 when the format does not read them:
//    U/J read neither; I/JALR/LOAD read rs1 only.
//  - ex_reg_write=1 for the opcodes LOAD, OP-IMM, OP-IMM-32, OP, OP-32, LUI, AUIPC, JAL, JALR, and only when rd!=0.
//    STORE, BRANCH and illegal give ex_reg_write=0 and ex_rd=0.
//  - Immediates are sign-extended to XLEN for the I/S/B/U/J formats. B and J have bit0=0.
//    U imm = {instr[31:12],12'b0}, sign-extended from bit 31.
//  - Unknown opcode: ex_illegal=1, ex_reg_write=0. The op still flows, ex_valid=1.
//  - Flush: both valids are cleared on the next edge. Flush outranks stall and backpressure.
//    if_valid in the flush cycle is dropped.
//  - Backpressure (ex_ready=0 with ex_valid=1): both stages hold and all outputs are stable.
//  - Stall while ex_ready=0: hold; the bubble is inserted when ID/EX drains.
//  - Reset mid-stream discards everything in flight. There is no replay.
// CONFIGURATION
//  - LOAD_USE_STALL_EN defined: stall = ex_valid & ex_opcode==LOAD & ex_rd!=0 & id_valid
//    & (rs1==ex_rd | rs2==ex_rd).
//    The condition is gated by id_valid, and rs1/rs2 are already masked as above.
//    Exactly one bubble is inserted once the load advances.
//  - Undefined: stall is tied 0 and no bubbles are inserted; software schedules around load-use.
// STRUCTURE
//  - riscv_pkg: opcode localparams (LOAD=7'b0000011 ... JAL=7'b1101111), the imm-format enum
//    {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J}, and the id_ex bundle struct.
//  - One sub-module, imm_gen: combinational (instr, fmt) -> XLEN imm.
//    Format selection stays in decode_stage.
// TESTING
//  - Reset: hold reset=0 for 2 clk with if_valid=1.
//    -> ex_valid=0, if_ready=0, all ex_* = 0. Release -> if_ready=1.
//  - Issue addi x5,x0,7 (0x00700293), pc=0x100.
//    -> 2 clk later: ex_valid=1, ex_imm=7, ex_rd=5, ex_reg_write=1, rs1 sampled=0.
//  - Issue lui x1,0x80000 (0x800000B7).
//    -> ex_imm=64'hFFFFFFFF80000000, rs1=rs2=0.
//    Then sd x7,8(x5) (0x0072B423) -> ex_imm=8, ex_reg_write=0, ex_rd=0.
//  - LOAD_USE_STALL_EN: issue ld x6,0(x5) (0x0002B303), then add x7,x6,x5 (0x005303B3).
//    -> stall=1 for 1 clk, one ex_valid=0 bubble, then the add is issued.
//    Undefined: no bubble.
//  - Assert ex_ready=0 for 3 clk with both stages full. -> if_ready=0 and outputs stable.
//    Assert flush on the 2nd of those clk. -> both valids=0 on the next edge, and that cycle's if_valid is dropped.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV64I decode types: opcode constants, immediate formats and the ID/EX bundle.
// Pure declarations; no latency or flow control of its own.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int INSTR_W    = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  illegal;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, register-file and execute-side signals of the decode stage.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if;
  import riscv_pkg::*;

  logic                  if_valid;
  logic                  if_ready;
  logic [INSTR_W-1:0]    if_instr;
  logic [XLEN-1:0]       if_pc;
  logic                  flush;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [XLEN-1:0]       rf_rdata1;
  logic [XLEN-1:0]       rf_rdata2;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_op1;
  logic [XLEN-1:0]       ex_op2;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic [6:0]            ex_opcode;
  logic [2:0]            ex_funct3;
  logic [6:0]            ex_funct7;
  logic                  ex_illegal;
  logic                  stall;

  modport master (
    output if_valid, if_instr, if_pc, flush, rf_rdata1, rf_rdata2, ex_ready,
    input  if_ready, rs1, rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
           ex_reg_write, ex_opcode, ex_funct3, ex_funct7, ex_illegal, stall
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, rf_rdata1, rf_rdata2, ex_ready,
    output if_ready, rs1, rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
           ex_reg_write, ex_opcode, ex_funct3, ex_funct7, ex_illegal, stall
  );

endinterface

// File: rtl/imm_gen.sv
// Sign-extended immediate for the selected format; combinational, no flow control.
// Bit 0 of B/J immediates is always zero; R format yields 0.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [INSTR_W-1:7] instr,
  input  imm_fmt_e           fmt,
  output logic [XLEN-1:0]    imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      FMT_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode: IF/ID + ID/EX registers, 2-cycle fetch-to-execute latency; holds under ex_ready=0.
// LOAD_USE_STALL_EN enables one-bubble load-use interlock; flush outranks stall and backpressure.
module decode_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [XLEN-1:0]    id_pc;
  logic               ex_valid;
  id_ex_t             ex_q;
  id_ex_t             id_dec;

  logic     ex_adv, id_adv, stall;
  logic     legal, wr_op, rs1_used, rs2_used, rd_kept;
  imm_fmt_e fmt;
  logic [XLEN-1:0]       imm;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rd_f;

  assign opcode = id_instr[6:0];
  assign rd_f   = id_instr[11:7];

  always_comb begin
    fmt      = FMT_R;
    legal    = 1'b1;
    wr_op    = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        fmt = FMT_I; rs1_used = 1'b1; wr_op = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt = FMT_I; rs1_used = 1'b1;
      end
      OPC_STORE:  begin fmt = FMT_S; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_BRANCH: begin fmt = FMT_B; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OP, OPC_OP_32: begin
        fmt = FMT_R; rs1_used = 1'b1; rs2_used = 1'b1; wr_op = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; wr_op = 1'b1; end
      OPC_JAL:            begin fmt = FMT_J; wr_op = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (id_instr[INSTR_W-1:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  // Unread source fields are masked so they can never match a load destination.
  assign bus.rs1 = rs1_used ? id_instr[19:15] : '0;
  assign bus.rs2 = rs2_used ? id_instr[24:20] : '0;

  assign rd_kept = legal && (opcode != OPC_STORE) && (opcode != OPC_BRANCH);

  always_comb begin
    id_dec           = '0;
    id_dec.pc        = id_pc;
    id_dec.op1       = bus.rf_rdata1;
    id_dec.op2       = bus.rf_rdata2;
    id_dec.imm       = imm;
    id_dec.rd        = rd_kept ? rd_f : '0;
    id_dec.reg_write = wr_op && (rd_f != '0);
    id_dec.opcode    = opcode;
    id_dec.funct3    = id_instr[14:12];
    id_dec.funct7    = id_instr[31:25];
    id_dec.illegal   = !legal;
  end

`ifdef LOAD_USE_STALL_EN
  assign stall = ex_valid && (ex_q.opcode == OPC_LOAD) && (ex_q.rd != '0) && id_valid &&
                 ((bus.rs1 == ex_q.rd) || (bus.rs2 == ex_q.rd));
`else
  assign stall = 1'b0;
`endif

  assign ex_adv       = !ex_valid || bus.ex_ready;
  assign id_adv       = ex_adv && !stall;
  assign bus.if_ready = reset && id_adv && !bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (bus.flush) begin
      id_valid <= 1'b0;
    end else if (id_adv) begin
      id_valid <= bus.if_valid;
      id_instr <= bus.if_instr;
      id_pc    <= bus.if_pc;
    end
  end

  // A stall cycle still advances ID/EX, which is what drops the bubble in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (bus.flush) begin
      ex_valid <= 1'b0;
    end else if (ex_adv) begin
      ex_valid <= id_valid && !stall;
      ex_q     <= id_dec;
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_op1       = ex_q.op1;
  assign bus.ex_op2       = ex_q.op2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_opcode    = ex_q.opcode;
  assign bus.ex_funct3    = ex_q.funct3;
  assign bus.ex_funct7    = ex_q.funct7;
  assign bus.ex_illegal   = ex_q.illegal;
  assign bus.stall        = stall;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a combinational register-file model (x[i] = 0x1000+i, x0 = 0).
module tb_decode_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [63:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : 64'h1000 + 64'(a);
  endfunction

  assign bus.rf_rdata1 = rf_val(bus.rs1);
  assign bus.rf_rdata2 = rf_val(bus.rs2);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    drive(1'b1, 32'h00700293, 64'h100);
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%0h want=0", bus.ex_valid); end
    total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL rst_if_ready got=%0h want=0", bus.if_ready); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h want=0", bus.stall); end
    total++; if (bus.ex_pc !== 64'd0 || bus.ex_imm !== 64'd0 || bus.ex_op1 !== 64'd0 || bus.ex_op2 !== 64'd0)
      begin bad++; $display("FAIL rst_ex_data got pc=%0h imm=%0h op1=%0h op2=%0h want=0", bus.ex_pc, bus.ex_imm, bus.ex_op1, bus.ex_op2); end
    total++; if (bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0 || bus.ex_opcode !== 7'd0 || bus.ex_illegal !== 1'b0)
      begin bad++; $display("FAIL rst_ex_ctl got rd=%0h rw=%0h opc=%0h ill=%0h want=0", bus.ex_rd, bus.ex_reg_write, bus.ex_opcode, bus.ex_illegal); end
    total++; if (bus.rs1 !== 5'd0 || bus.rs2 !== 5'd0) begin bad++; $display("FAIL rst_rs got=%0h/%0h want=0/0", bus.rs1, bus.rs2); end
    reset = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    #1;
    total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL rst_release_if_ready got=%0h want=1", bus.if_ready); end
  endtask

  task automatic test_addi;
    drive(1'b1, 32'h00700293, 64'h100);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    total++; if (bus.rs1 !== 5'd0 || bus.rs2 !== 5'd0) begin bad++; $display("FAIL addi_rs got=%0h/%0h want=0/0", bus.rs1, bus.rs2); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL addi_lat1 got=%0h want=0", bus.ex_valid); end
    tick();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL addi_ex_valid got=%0h want=1", bus.ex_valid); end
    total++; if (bus.ex_imm !== 64'd7) begin bad++; $display("FAIL addi_imm got=%0h want=7", bus.ex_imm); end
    total++; if (bus.ex_rd !== 5'd5 || bus.ex_reg_write !== 1'b1) begin bad++; $display("FAIL addi_rd got rd=%0h rw=%0h want 5/1", bus.ex_rd, bus.ex_reg_write); end
    total++; if (bus.ex_pc !== 64'h100 || bus.ex_opcode !== 7'h13 || bus.ex_op1 !== 64'd0)
      begin bad++; $display("FAIL addi_misc got pc=%0h opc=%0h op1=%0h want 100/13/0", bus.ex_pc, bus.ex_opcode, bus.ex_op1); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0h want=0", bus.ex_valid); end
  endtask

  task automatic test_lui_sd;
    drive(1'b1, 32'h800000B7, 64'h104);
    tick();
    total++; if (bus.rs1 !== 5'd0 || bus.rs2 !== 5'd0) begin bad++; $display("FAIL lui_rs got=%0h/%0h want=0/0", bus.rs1, bus.rs2); end
    drive(1'b1, 32'h0072B423, 64'h108);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    total++; if (bus.ex_imm !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL lui_imm got=%0h want=ffffffff80000000", bus.ex_imm); end
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd1 || bus.ex_reg_write !== 1'b1)
      begin bad++; $display("FAIL lui_ctl got v=%0h rd=%0h rw=%0h want 1/1/1", bus.ex_valid, bus.ex_rd, bus.ex_reg_write); end
    total++; if (bus.rs1 !== 5'd5 || bus.rs2 !== 5'd7) begin bad++; $display("FAIL sd_rs got=%0h/%0h want=5/7", bus.rs1, bus.rs2); end
    tick();
    total++; if (bus.ex_imm !== 64'd8) begin bad++; $display("FAIL sd_imm got=%0h want=8", bus.ex_imm); end
    total++; if (bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0) begin bad++; $display("FAIL sd_rd got rd=%0h rw=%0h want 0/0", bus.ex_rd, bus.ex_reg_write); end
    total++; if (bus.ex_op1 !== 64'h1005 || bus.ex_op2 !== 64'h1007 || bus.ex_funct3 !== 3'd3)
      begin bad++; $display("FAIL sd_ops got op1=%0h op2=%0h f3=%0h want 1005/1007/3", bus.ex_op1, bus.ex_op2, bus.ex_funct3); end
    tick();
  endtask

  task automatic test_load_use;
    drive(1'b1, 32'h0002B303, 64'h300);
    tick();
    total++; if (bus.rs1 !== 5'd5 || bus.rs2 !== 5'd0) begin bad++; $display("FAIL ld_rs got=%0h/%0h want=5/0", bus.rs1, bus.rs2); end
    drive(1'b1, 32'h005303B3, 64'h304);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    #1;
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.ex_opcode !== 7'h03)
      begin bad++; $display("FAIL ld_ex got v=%0h rd=%0h opc=%0h want 1/6/3", bus.ex_valid, bus.ex_rd, bus.ex_opcode); end
`ifdef LOAD_USE_STALL_EN
    total++; if (bus.stall !== 1'b1 || bus.if_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got st=%0h rdy=%0h want 1/0", bus.stall, bus.if_ready); end
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL lu_bubble got v=%0h st=%0h want 0/0", bus.ex_valid, bus.stall); end
    tick();
`else
    total++; if (bus.stall !== 1'b0 || bus.if_ready !== 1'b1) begin bad++; $display("FAIL lu_nostall got st=%0h rdy=%0h want 0/1", bus.stall, bus.if_ready); end
    tick();
`endif
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h304 || bus.ex_rd !== 5'd7)
      begin bad++; $display("FAIL add_ex got v=%0h pc=%0h rd=%0h want 1/304/7", bus.ex_valid, bus.ex_pc, bus.ex_rd); end
    total++; if (bus.ex_op1 !== 64'h1006 || bus.ex_op2 !== 64'h1005)
      begin bad++; $display("FAIL add_ops got op1=%0h op2=%0h want 1006/1005", bus.ex_op1, bus.ex_op2); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_drain got=%0h want=0", bus.ex_valid); end
  endtask

  task automatic test_jal_illegal;
    drive(1'b1, 32'hFFDFF0EF, 64'h400);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 64'h404);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    total++; if (bus.ex_imm !== 64'hFFFFFFFFFFFFFFFC) begin bad++; $display("FAIL jal_imm got=%0h want=fffffffffffffffc", bus.ex_imm); end
    total++; if (bus.ex_rd !== 5'd1 || bus.ex_reg_write !== 1'b1 || bus.ex_illegal !== 1'b0)
      begin bad++; $display("FAIL jal_ctl got rd=%0h rw=%0h ill=%0h want 1/1/0", bus.ex_rd, bus.ex_reg_write, bus.ex_illegal); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got v=%0h ill=%0h want 1/1", bus.ex_valid, bus.ex_illegal); end
    total++; if (bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_opcode !== 7'h7F)
      begin bad++; $display("FAIL ill_ctl got rw=%0h rd=%0h opc=%0h want 0/0/7f", bus.ex_reg_write, bus.ex_rd, bus.ex_opcode); end
    tick();
  endtask

  task automatic test_backpressure_flush;
    drive(1'b1, 32'h00700293, 64'h200);
    tick();
    drive(1'b1, 32'h800000B7, 64'h204);
    tick();
    drive(1'b1, 32'h0072B423, 64'h208);
    bus.ex_ready = 1'b0;
    #1;
    total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL bp_if_ready got=%0h want=0", bus.if_ready); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h200 || bus.ex_imm !== 64'd7)
      begin bad++; $display("FAIL bp_hold got v=%0h pc=%0h imm=%0h want 1/200/7", bus.ex_valid, bus.ex_pc, bus.ex_imm); end
    total++; if (bus.rs1 !== 5'd0 || bus.rs2 !== 5'd0 || bus.if_ready !== 1'b0)
      begin bad++; $display("FAIL bp_id_hold got rs=%0h/%0h rdy=%0h want 0/0/0", bus.rs1, bus.rs2, bus.if_ready); end
    bus.flush = 1'b1;
    #1;
    total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL fl_if_ready got=%0h want=0", bus.if_ready); end
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_ex_valid got=%0h want=0", bus.ex_valid); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_id_empty got=%0h want=0", bus.ex_valid); end
    bus.ex_ready = 1'b1;
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_dropped got=%0h want=0", bus.ex_valid); end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 32'h00700293, 64'h500);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h500) begin bad++; $display("FAIL mid_pre got v=%0h pc=%0h want 1/500", bus.ex_valid, bus.ex_pc); end
    reset = 1'b0;
    #1;
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 64'd0 || bus.if_ready !== 1'b0)
      begin bad++; $display("FAIL mid_rst got v=%0h pc=%0h rdy=%0h want 0/0/0", bus.ex_valid, bus.ex_pc, bus.if_ready); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL mid_after got=%0h want=0", bus.ex_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui_sd();
    test_load_use();
    test_jal_illegal();
    test_backpressure_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
